// File: rtl/top_rand_inv_pkg.sv
// Shared definitions for the inverse scrambler: word/counter widths, feedback
// taps of the x^6+x^5+1 forward scrambler, FSM encoding and the inverse step.
package top_rand_inv_pkg;

   localparam int WORD_W = 6;
   localparam int CNT_W  = 3;
   localparam int TAP_HI = 5;
   localparam int TAP_LO = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Forward step shifts left and feeds s[HI]^s[LO] into bit 0, so undoing it
   // shifts right and rebuilds s[HI] from the fed-back bit and the old s[LO].
   function automatic logic [WORD_W-1:0] inv_step(input logic [WORD_W-1:0] s);
      logic [WORD_W-1:0] r;
      r         = s >> 1;
      r[TAP_HI] = s[0] ^ s[TAP_LO + 1];
      return r;
   endfunction

endpackage

// File: rtl/rand_inv_dp.sv
// Datapath for top_rand_inv: working register, inverse-step logic, step
// counter and the output word/flag registers.
module rand_inv_dp
   import top_rand_inv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              shift_en_i,
   input  logic              out_en_i,
   input  logic [WORD_W-1:0] data_i,
   output logic [CNT_W-1:0]  cnt_o,
   output logic [WORD_W-1:0] data_o,
   output logic [1:0]        result_o
);

   logic [WORD_W-1:0] work_q, work_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] dout_q, dout_d;
   logic [1:0]        res_q, res_d;

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block leaves
      // a variable unassigned, which would otherwise infer a latch.
      work_d = work_q;
      cnt_d  = cnt_q;
      dout_d = dout_q;
      res_d  = res_q;
      if (load_i) begin
         work_d = data_i;
         cnt_d  = '0;
      end else if (shift_en_i) begin
         work_d = inv_step(work_q);
         cnt_d  = cnt_q + CNT_W'(1);
      end
      if (out_en_i) begin
         dout_d = work_q;
         res_d  = {~|work_q, ^work_q};
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst) begin
         work_q <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
         res_q  <= '0;
      end else begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         res_q  <= res_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign data_o   = dout_q;
   assign result_o = res_q;

endmodule

// File: rtl/top_rand_inv.sv
// Inverse scrambler top: IDLE/SHIFT/DONE controller sequencing rand_inv_dp,
// one inverse step per SHIFT cycle, results published from DONE.
module top_rand_inv
   import top_rand_inv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] data_in,
   input  logic [CNT_W-1:0]  num_steps,
   output logic [WORD_W-1:0] data_out,
   output logic [1:0]        result,
   output logic              busy,
   output logic              done
);

   state_t           state_q;
   logic [CNT_W-1:0] steps_q;
   logic [CNT_W-1:0] cnt;
   logic             busy_q;
   logic             done_q;
   logic             load;
   logic             shift_en;
   logic             out_en;

   assign load     = (state_q == IDLE) && start;
   assign shift_en = (state_q == SHIFT);
   assign out_en   = (state_q == DONE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         steps_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  steps_q <= num_steps;
                  busy_q  <= 1'b1;
                  state_q <= (num_steps == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               // steps_q is at least 1 here, so the subtraction cannot wrap.
               if (cnt == steps_q - CNT_W'(1)) begin
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   rand_inv_dp u_dp (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .shift_en_i (shift_en),
      .out_en_i   (out_en),
      .data_i     (data_in),
      .cnt_o      (cnt),
      .data_o     (data_out),
      .result_o   (result)
   );

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_top_rand_inv.sv
// Self-checking bench for top_rand_inv: directed vectors, busy/reset/back-to-back
// scenarios and an exhaustive randomized sweep against a preimage-search model.
module tb_top_rand_inv;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [5:0] data_in = '0;
   logic [2:0] num_steps = '0;
   logic [5:0] data_out;
   logic [1:0] result;
   logic       busy;
   logic       done;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   top_rand_inv dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .data_in   (data_in),
      .num_steps (num_steps),
      .data_out  (data_out),
      .result    (result),
      .busy      (busy),
      .done      (done)
   );

   function automatic logic [5:0] fwd(input logic [5:0] s);
      return {s[4:0], s[5] ^ s[4]};
   endfunction

   function automatic logic [5:0] fwd_n(input logic [5:0] s, input int n);
      logic [5:0] x = s;
      for (int k = 0; k < n; k++) x = fwd(x);
      return x;
   endfunction

   // Expected word: the unique preimage of d under n forward steps.
   function automatic logic [5:0] model_word(input logic [5:0] d, input int n);
      for (int w = 0; w < 64; w++)
         if (fwd_n(6'(w), n) == d) return 6'(w);
      return 6'bx;
   endfunction

   function automatic logic [1:0] model_res(input logic [5:0] w);
      return {w == 6'd0, ($countones(w) % 2) == 1};
   endfunction

   task automatic do_op(input logic [5:0] d, input logic [2:0] n, input bit noisy,
                        output int lat, output logic [5:0] dout, output logic [1:0] res,
                        output bit busy_ok, output bit held_ok, output bit single_ok);
      logic [5:0] prev;
      bit         got;
      @(negedge clk);
      prev = data_out; start = 1'b1; data_in = d; num_steps = n;
      @(posedge clk); #1;
      busy_ok = (busy === 1'b1);
      lat = 0; got = 1'b0; held_ok = 1'b1;
      while (!got && lat < 20) begin
         @(negedge clk);
         start     = noisy ? 1'($urandom) : 1'b0;
         data_in   = 6'($urandom);
         num_steps = 3'($urandom);
         @(posedge clk); #1;
         lat++;
         if (done === 1'b1) got = 1'b1;
         else if (data_out !== prev) held_ok = 1'b0;
      end
      start   = 1'b0;
      dout    = data_out;
      res     = result;
      busy_ok = busy_ok && (busy === 1'b0);
      @(posedge clk); #1;
      single_ok = (done === 1'b0);
      if (!got) lat = -1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b1; data_in = 6'b101010; num_steps = 3'd3;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++; if (data_out !== 6'd0) $display("FAIL reset_data_out got %b want 000000", data_out); else pass_cnt++;
      total_cnt++; if (result !== 2'b00) $display("FAIL reset_result got %b want 00", result); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy_over_start got %b want 0", busy); else pass_cnt++;
      @(negedge clk); start = 1'b0; rst = 1'b1;
   endtask

   task automatic test_directed();
      logic [5:0] dv[5] = '{6'b000010, 6'b110000, 6'b000100, 6'b101101, 6'b000000};
      int         nv[5] = '{1, 1, 2, 0, 7};
      logic [5:0] ev[5] = '{6'b000001, 6'b111000, 6'b000001, 6'b101101, 6'b000000};
      logic [1:0] rv[5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
      int lat; logic [5:0] dout; logic [1:0] res; bit b_ok, h_ok, s_ok;
      for (int i = 0; i < 5; i++) begin
         do_op(dv[i], 3'(nv[i]), 1'b0, lat, dout, res, b_ok, h_ok, s_ok);
         total_cnt++; if (lat !== nv[i] + 1) $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, nv[i] + 1); else pass_cnt++;
         total_cnt++; if (dout !== ev[i]) $display("FAIL dir_data_out[%0d] got %b want %b", i, dout, ev[i]); else pass_cnt++;
         total_cnt++; if (res !== rv[i]) $display("FAIL dir_result[%0d] got %b want %b", i, res, rv[i]); else pass_cnt++;
         total_cnt++; if (!b_ok) $display("FAIL dir_busy[%0d] got 0 want 1", i); else pass_cnt++;
         total_cnt++; if (!h_ok) $display("FAIL dir_output_hold[%0d] got changed want held", i); else pass_cnt++;
         total_cnt++; if (!s_ok) $display("FAIL dir_done_width[%0d] got 2+ cycles want 1", i); else pass_cnt++;
      end
   endtask

   task automatic test_busy_ignore();
      int lat; logic [5:0] dout; logic [1:0] res; bit b_ok, h_ok, s_ok;
      int extra = 0;
      do_op(6'b100111, 3'd7, 1'b1, lat, dout, res, b_ok, h_ok, s_ok);
      total_cnt++; if (lat !== 8) $display("FAIL busy_latency got %0d want 8", lat); else pass_cnt++;
      total_cnt++; if (dout !== model_word(6'b100111, 7)) $display("FAIL busy_data_out got %b want %b", dout, model_word(6'b100111, 7)); else pass_cnt++;
      total_cnt++; if (res !== model_res(model_word(6'b100111, 7))) $display("FAIL busy_result got %b want %b", res, model_res(model_word(6'b100111, 7))); else pass_cnt++;
      repeat (10) begin
         @(posedge clk); #1;
         if (done === 1'b1) extra++;
      end
      total_cnt++; if (extra !== 0 || !s_ok) $display("FAIL busy_extra_done got %0d want 0", extra + (s_ok ? 0 : 1)); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int lat; logic [5:0] dout; logic [1:0] res; bit b_ok, h_ok, s_ok;
      int seen = 0;
      do_op(6'b000010, 3'd1, 1'b0, lat, dout, res, b_ok, h_ok, s_ok);
      @(negedge clk); start = 1'b1; data_in = 6'b110101; num_steps = 3'd5;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      total_cnt++; if (data_out !== 6'd0) $display("FAIL midrst_data_out got %b want 000000", data_out); else pass_cnt++;
      total_cnt++; if (result !== 2'b00) $display("FAIL midrst_result got %b want 00", result); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass_cnt++;
      @(negedge clk); rst = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      total_cnt++; if (seen !== 0) $display("FAIL midrst_no_done got %0d pulses want 0", seen); else pass_cnt++;
      do_op(6'b110000, 3'd1, 1'b0, lat, dout, res, b_ok, h_ok, s_ok);
      total_cnt++; if (lat !== 2 || dout !== 6'b111000 || res !== 2'b01)
         $display("FAIL midrst_recover got lat=%0d %b %b want lat=2 111000 01", lat, dout, res); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [5:0] a_w, b_w;
      int a_n, b_n, lat;
      bit got;
      for (int r = 0; r < 4; r++) begin
         a_w = 6'($urandom); b_w = 6'($urandom);
         a_n = $urandom_range(1, 7); b_n = $urandom_range(0, 7);
         @(negedge clk); start = 1'b1; data_in = a_w; num_steps = 3'(a_n);
         @(posedge clk); #1;
         @(negedge clk); data_in = b_w; num_steps = 3'(b_n);
         lat = 0; got = 1'b0;
         while (!got && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (done === 1'b1) got = 1'b1;
         end
         total_cnt++; if (!got || lat !== a_n + 1 || data_out !== model_word(a_w, a_n))
            $display("FAIL b2b_first[%0d] got lat=%0d %b want lat=%0d %b", r, got ? lat : -1, data_out, a_n + 1, model_word(a_w, a_n)); else pass_cnt++;
         @(posedge clk); #1;
         total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_restart[%0d] got busy=%b want 1", r, busy); else pass_cnt++;
         start = 1'b0;
         lat = 0; got = 1'b0;
         while (!got && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (done === 1'b1) got = 1'b1;
         end
         total_cnt++; if (!got || lat !== b_n + 1 || data_out !== model_word(b_w, b_n) || result !== model_res(model_word(b_w, b_n)))
            $display("FAIL b2b_second[%0d] got lat=%0d %b %b want lat=%0d %b %b", r, got ? lat : -1, data_out, result,
                     b_n + 1, model_word(b_w, b_n), model_res(model_word(b_w, b_n))); else pass_cnt++;
      end
   endtask

   task automatic test_random();
      int lat; logic [5:0] dout; logic [1:0] res; bit b_ok, h_ok, s_ok;
      logic [5:0] exp_w;
      for (int d = 0; d < 64; d++) begin
         for (int n = 0; n < 8; n++) begin
            do_op(6'(d), 3'(n), 1'($urandom), lat, dout, res, b_ok, h_ok, s_ok);
            exp_w = model_word(6'(d), n);
            total_cnt++; if (lat !== n + 1) $display("FAIL rnd_latency d=%0d n=%0d got %0d want %0d", d, n, lat, n + 1); else pass_cnt++;
            total_cnt++; if (dout !== exp_w) $display("FAIL rnd_data_out d=%0d n=%0d got %b want %b", d, n, dout, exp_w); else pass_cnt++;
            total_cnt++; if (res !== model_res(exp_w)) $display("FAIL rnd_result d=%0d n=%0d got %b want %b", d, n, res, model_res(exp_w)); else pass_cnt++;
            total_cnt++; if (fwd_n(dout, n) !== 6'(d)) $display("FAIL rnd_roundtrip d=%0d n=%0d got %b want %b", d, n, fwd_n(dout, n), 6'(d)); else pass_cnt++;
            total_cnt++; if (!(b_ok && h_ok && s_ok)) $display("FAIL rnd_handshake d=%0d n=%0d got busy=%0d hold=%0d single=%0d want 111", d, n, b_ok, h_ok, s_ok); else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
